// File: rtl/psum_activation_stage.sv
// psum_activation_stage
//   Row-end consumer of the systolic MAC array. Adds a per-neuron bias to the
//   signed partial sum leaving the last PE of a row, rescales by a fixed
//   rounding right-shift, optionally applies ReLU, saturates to the activation
//   width and buffers the result in a first-word fall-through FIFO.
//
// Ports
//   clk, rst_overall        clock (rising edge), async active-low reset
//   flush                   sync clear of pipeline + FIFO (bias kept)
//   in_valid/in_ready       psum_in handshake (in_ready never looks at in_valid)
//   psum_in                 signed partial sum, totalwidth bits
//   bias_load/bias_in       bias register write port
//   relu_en                 clamp negatives to 0, captured with the psum
//   out_valid/out_ready     act_out handshake
//   act_out                 signed activation (FIFO head, holds when empty)
//   fifo_count              FIFO occupancy
module psum_activation_stage #(
  parameter int datawidth  = 11,
  parameter int totalwidth = 2 * datawidth,
  parameter int frac_shift = 4,
  parameter int fifo_depth = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_overall,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [totalwidth-1:0]         psum_in,
  input  logic                                 bias_load,
  input  logic signed [totalwidth-1:0]         bias_in,
  input  logic                                 relu_en,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [datawidth-1:0]          act_out,
  output logic [$clog2(fifo_depth+1)-1:0]      fifo_count
);

  localparam int T  = totalwidth;
  localparam int D  = datawidth;
  localparam int CW = $clog2(fifo_depth + 1);
  localparam int PW = $clog2(fifo_depth);

  localparam logic signed [T-1:0] TMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0] TMIN = {1'b1, {(T-1){1'b0}}};
  localparam logic signed [D-1:0] DMAX = {1'b0, {(D-1){1'b1}}};
  localparam logic signed [D-1:0] DMIN = {1'b1, {(D-1){1'b0}}};
  localparam logic signed [T:0]   RND  = (T+1)'(1) << (frac_shift - 1);

  logic signed [T-1:0] bias_q;
  logic signed [T-1:0] s1_q;
  logic                s1_relu_q;
  logic                s1_valid_q;
  logic signed [D-1:0] mem [fifo_depth];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic signed [D-1:0] last_q;

  logic [T:0]          sum_w;
  logic signed [T-1:0] s1_d;
  logic signed [T:0]   ext_w;
  logic signed [T:0]   rnd_w;
  logic signed [T:0]   r_w;
  logic signed [D-1:0] res_w;
  logic [CW:0]         occ_w;
  logic                accept, wr_en, pop;

  always_comb begin
    // Stage 1: add in T+1 bits, overflow shows as disagreeing top two bits.
    sum_w = {psum_in[T-1], psum_in} + {bias_q[T-1], bias_q};
    if (sum_w[T] != sum_w[T-1]) s1_d = sum_w[T] ? TMIN : TMAX;
    else                        s1_d = sum_w[T-1:0];

    // Stage 2: round half up then arithmetic shift, ReLU, saturate.
    ext_w = {s1_q[T-1], s1_q};
    rnd_w = (ext_w + RND) >>> frac_shift;
    r_w   = (s1_relu_q && rnd_w[T]) ? '0 : rnd_w;
    if ((&r_w[T:D-1]) || !(|r_w[T:D-1])) res_w = r_w[D-1:0];
    else                                 res_w = r_w[T] ? DMIN : DMAX;

    // Reserving a slot for the element in stage 1 means stage 2 never
    // writes into a full FIFO, so the pipeline needs no stall path.
    occ_w    = {1'b0, count_q} + (CW+1)'(s1_valid_q);
    in_ready = occ_w < (CW+1)'(fifo_depth);

    out_valid  = (count_q != '0);
    act_out    = out_valid ? mem[rd_ptr_q] : last_q;
    fifo_count = count_q;

    accept = in_valid && in_ready;
    wr_en  = s1_valid_q;
    pop    = out_valid && out_ready;

    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_overall) begin
    if (!rst_overall)   bias_q <= '0;
    else if (bias_load) bias_q <= bias_in;
  end

  always_ff @(posedge clk or negedge rst_overall) begin
    if (!rst_overall) begin
      s1_q       <= '0;
      s1_relu_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      // Keep showing the head that was visible, so act_out holds once empty.
      if (out_valid) last_q <= mem[rd_ptr_q];
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_q      <= s1_d;
        s1_relu_q <= relu_en;
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        last_q   <= mem[rd_ptr_q];
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only read while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (!flush && wr_en) mem[wr_ptr_q] <= res_w;
  end

endmodule

// File: tb/tb_psum_activation_stage.sv
module tb_psum_activation_stage;

  localparam int D     = 11;
  localparam int T     = 2 * D;
  localparam int FS    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst_overall = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [T-1:0] psum_in = '0;
  logic                bias_load = 1'b0;
  logic signed [T-1:0] bias_in = '0;
  logic                relu_en = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [D-1:0] act_out;
  logic [CW-1:0]       fifo_count;

  psum_activation_stage #(
    .datawidth (D),
    .totalwidth(T),
    .frac_shift(FS),
    .fifo_depth(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_overall(rst_overall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .psum_in    (psum_in),
    .bias_load  (bias_load),
    .bias_in    (bias_in),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .act_out    (act_out),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    sb[$];
  longint bias_m = 0;
  int    acc_cnt = 0;
  int    pop_cnt = 0;
  bit    rand_rdy = 0;
  bit    chk_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the documented rules.
  function automatic int model(input longint p, input longint b, input bit relu);
    longint s, r;
    longint tmax = (longint'(1) << (T - 1)) - 1;
    longint tmin = -(longint'(1) << (T - 1));
    s = p + b;
    if (s > tmax) s = tmax;
    if (s < tmin) s = tmin;
    r = (s + (longint'(1) << (FS - 1))) >>> FS;
    if (relu && r < 0) r = 0;
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
    return int'(r);
  endfunction

  // Inputs change only at posedge+1, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_overall) begin
      if (flush) sb.delete();
      else if (in_valid && in_ready) begin
        sb.push_back(model(longint'(psum_in), bias_m, relu_en));
        acc_cnt++;
      end
      if (bias_load) bias_m = longint'(bias_in);
    end
  end

  always @(negedge rst_overall) begin
    sb.delete();
    bias_m = 0;
  end

  // Monitor: every handshake that will complete at the next edge is checked.
  always @(negedge clk) begin
    if (rst_overall && !flush && out_valid && out_ready) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got output %0d with nothing expected", act_out);
      end else begin
        chk("act_out_sb", longint'(act_out), longint'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bias_load = 1'b0;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic signed [T-1:0] p, input bit r);
    bit ok = 0;
    in_valid = 1'b1;
    psum_in  = p;
    relu_en  = r;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      if (chk_cnt && (fifo_count < 2 || fifo_count > DEPTH))
        chk("fifo_count_stream", longint'(fifo_count), 2);
      tick();
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic load_bias(input logic signed [T-1:0] b);
    bias_load = 1'b1;
    bias_in   = b;
    tick();
  endtask

  task automatic wait_out(input string nm, input int exp);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
    else       chk(nm, longint'(act_out), longint'(exp));
    tick();
  endtask

  function automatic logic signed [T-1:0] rnd_psum();
    case ($urandom_range(0, 2))
      0:       return T'($urandom);
      1:       return T'(int'($urandom_range(0, 4000)) - 2000);
      default: return $urandom_range(0, 1) ? T'((1 << (T-1)) - 1 - int'($urandom_range(0, 300)))
                                           : T'(-(1 << (T-1)) + int'($urandom_range(0, 300)));
    endcase
  endfunction

  initial begin
    int a0, p0;
    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_act_out", act_out, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #3 rst_overall = 1'b1;
    tick();

    // Basic path with bias 0, including first-result latency.
    send(T'(160), 0);
    chk("lat_edgeN_out_valid", out_valid, 0);
    tick();
    chk("lat_edgeN1_out_valid", out_valid, 1);
    chk("lat_edgeN1_act_out", act_out, 10);
    idle(2);
    send(T'(-40), 0); wait_out("neg_norelu", -2);
    send(T'(-40), 1); wait_out("neg_relu", 0);
    send(T'(23), 0);  wait_out("round_23", 1);
    send(T'(24), 0);  wait_out("round_24", 2);

    // Saturation
    load_bias(T'(100));
    send(T'(2097151), 0);  wait_out("sat_pos", 1023);
    load_bias(-T'(5));
    send(-T'(2097152), 0); wait_out("sat_neg", -1024);

    // Bias timing: load on the same edge as an accept
    load_bias('0);
    bias_load = 1'b1; bias_in = T'(32);
    send('0, 0); wait_out("bias_old", 0);
    send('0, 0); wait_out("bias_new", 2);
    idle(2);

    // Backpressure: 6 back-to-back elements against a stalled output
    out_ready = 1'b0;
    a0 = acc_cnt;
    for (int k = 0; k < 4; k++) send(T'(16 * (k + 1)), 0);
    in_valid = 1'b1; psum_in = T'(80); relu_en = 1'b0;
    repeat (4) tick();
    chk("bp_accepted", acc_cnt - a0, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_fifo_count", fifo_count, 4);
    p0 = pop_cnt;
    out_ready = 1'b1;
    send(T'(80), 0);
    send(T'(96), 0);
    idle(8);
    chk("bp_pops", pop_cnt - p0, 6);
    chk("bp_accepted_all", acc_cnt - a0, 6);

    // Full FIFO with continuous push and pop
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(rnd_psum(), 0);
    idle(2);
    chk("full_count", fifo_count, 4);
    out_ready = 1'b1;
    chk_cnt = 1;
    for (int k = 0; k < 20; k++) send(rnd_psum(), 1'($urandom_range(0, 1)));
    chk_cnt = 0;
    idle(8);
    chk("stream_drained", sb.size(), 0);

    // Flush with 3 buffered
    load_bias(T'(16));
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(T'(1000 + k), 0);
    idle(2);
    chk("pre_flush_count", fifo_count, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_count", fifo_count, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(T'(48), 0); wait_out("flush_bias_kept", 4);

    // Async reset mid-stream with 3 buffered
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(T'(160), 0);
    idle(2);
    chk("pre_rst_count", fifo_count, 3);
    #2 rst_overall = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_act_out", act_out, 0);
    @(posedge clk); #3 rst_overall = 1'b1;
    #1;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_fifo_count", fifo_count, 0);
    chk("rel_act_out", act_out, 0);
    chk("rel_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(T'(160), 0); wait_out("post_rst_bias0", 10);

    // Randomized traffic
    rand_rdy = 1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        bias_load = 1'b1;
        bias_in = rnd_psum();
      end
      send(rnd_psum(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    idle(12);
    chk("random_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
